// File: rtl/iterative_comparator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : comparator_pkg
// Description : Shared state encoding and result-flag ordering for the
//               iterative magnitude comparator.
// Revision    : 1.0 - initial release
// ============================================================================
package comparator_pkg;

  // Controller states. Encoding 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit positions of the result flags inside the 3-bit result vector.
  localparam int FLAG_EQ = 0;
  localparam int FLAG_GT = 1;
  localparam int FLAG_LT = 2;
  localparam int FLAG_W  = 3;

endpackage : comparator_pkg
`default_nettype wire

// File: rtl/iterative_comparator_chunk_compare.sv
`default_nettype none
// ============================================================================
// Module      : chunk_compare
// Description : Combinational unsigned compare of one ChunkBits-wide slice.
//               Exactly one of o_gt/o_lt/o_eq is high for any input.
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_compare #(
  parameter int ChunkBits = 8
) (
  input  logic [ChunkBits-1:0] i_a,
  input  logic [ChunkBits-1:0] i_b,
  output logic                 o_gt,
  output logic                 o_lt,
  output logic                 o_eq
);

  assign o_gt = (i_a >  i_b);
  assign o_lt = (i_a <  i_b);
  assign o_eq = (i_a == i_b);

endmodule : chunk_compare
`default_nettype wire

// File: rtl/iterative_comparator.sv
`default_nettype none
// ============================================================================
// Module      : iterative_comparator
// Description : Multi-cycle magnitude comparator. Compares two NrOfBits-wide
//               operands ChunkBits at a time, most significant chunk first,
//               stopping at the first differing chunk. Signed/unsigned mode
//               is chosen per operation; the result is registered and
//               announced with a one-cycle Done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module iterative_comparator
  import comparator_pkg::*;
#(
  parameter int NrOfBits  = 32,
  parameter int ChunkBits = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic                TwosComplement,
  input  logic [NrOfBits-1:0] DataA,
  input  logic [NrOfBits-1:0] DataB,
  output logic                Busy,
  output logic                Done,
  output logic                A_EQ_B,
  output logic                A_GT_B,
  output logic                A_LT_B
);

  localparam int NrOfChunks = NrOfBits / ChunkBits;
  localparam int IDXW       = (NrOfChunks > 1) ? $clog2(NrOfChunks) : 1;

  localparam logic [IDXW-1:0]     C_LAST_IDX = IDXW'(NrOfChunks - 1);
  localparam logic [NrOfBits-1:0] C_MSB_MASK = {1'b1, {(NrOfBits-1){1'b0}}};

  state_t              r_state;
  logic [NrOfBits-1:0] r_a;
  logic [NrOfBits-1:0] r_b;
  logic                r_tc;
  logic [IDXW-1:0]     r_idx;
  logic [FLAG_W-1:0]   r_flags;
  logic                r_busy;
  logic                r_done;

  logic [NrOfBits-1:0]  w_a_eff;
  logic [NrOfBits-1:0]  w_b_eff;
  logic [ChunkBits-1:0] w_chunk_a;
  logic [ChunkBits-1:0] w_chunk_b;
  logic                 w_gt;
  logic                 w_lt;
  logic                 w_eq;
  logic                 w_accept;

  // Flipping both sign bits maps two's-complement order onto unsigned order,
  // so the chunk datapath only ever needs an unsigned compare.
  assign w_a_eff = r_tc ? (r_a ^ C_MSB_MASK) : r_a;
  assign w_b_eff = r_tc ? (r_b ^ C_MSB_MASK) : r_b;

  assign w_chunk_a = w_a_eff[int'(r_idx) * ChunkBits +: ChunkBits];
  assign w_chunk_b = w_b_eff[int'(r_idx) * ChunkBits +: ChunkBits];

  chunk_compare #(
    .ChunkBits (ChunkBits)
  ) u_chunk_compare (
    .i_a  (w_chunk_a),
    .i_b  (w_chunk_b),
    .o_gt (w_gt),
    .o_lt (w_lt),
    .o_eq (w_eq)
  );

  // A request is honoured only when no compare is in flight.
  assign w_accept = Start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Controller: operand capture, chunk walk and registered result/status.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_tc    <= 1'b0;
      r_idx   <= '0;
      r_flags <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= DataA;
        r_b     <= DataB;
        r_tc    <= TwosComplement;
        r_idx   <= C_LAST_IDX;
        r_flags <= '0;
        r_state <= ST_RUN;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_busy <= 1'b0;
          end
          ST_RUN: begin
            if (w_gt) begin
              r_flags[FLAG_GT] <= 1'b1;
              r_state          <= ST_DONE;
              r_busy           <= 1'b0;
              r_done           <= 1'b1;
            end else if (w_lt) begin
              r_flags[FLAG_LT] <= 1'b1;
              r_state          <= ST_DONE;
              r_busy           <= 1'b0;
              r_done           <= 1'b1;
            end else if (w_eq && (r_idx == '0)) begin
              r_flags[FLAG_EQ] <= 1'b1;
              r_state          <= ST_DONE;
              r_busy           <= 1'b0;
              r_done           <= 1'b1;
            end else begin
              r_idx <= r_idx - 1'b1;
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Busy   = r_busy;
  assign Done   = r_done;
  assign A_EQ_B = r_flags[FLAG_EQ];
  assign A_GT_B = r_flags[FLAG_GT];
  assign A_LT_B = r_flags[FLAG_LT];

endmodule : iterative_comparator
`default_nettype wire

// File: tb/tb_iterative_comparator.sv
`default_nettype none
// ============================================================================
// Module      : tb_iterative_comparator
// Description : Self-checking bench for iterative_comparator (32-bit, 8-bit
//               chunks). Expected flags come from whole-word integer compares
//               and expected latency from counting equal leading bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iterative_comparator;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic        TwosComplement;
  logic [31:0] DataA;
  logic [31:0] DataB;
  logic        Busy;
  logic        Done;
  logic        A_EQ_B;
  logic        A_GT_B;
  logic        A_LT_B;

  int total = 0;
  int bad   = 0;

  iterative_comparator #(
    .NrOfBits  (32),
    .ChunkBits (8)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Start          (Start),
    .TwosComplement (TwosComplement),
    .DataA          (DataA),
    .DataB          (DataB),
    .Busy           (Busy),
    .Done           (Done),
    .A_EQ_B         (A_EQ_B),
    .A_GT_B         (A_GT_B),
    .A_LT_B         (A_LT_B)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // {Busy, Done, LT, GT, EQ}
  function automatic logic [4:0] outs();
    return {Busy, Done, A_LT_B, A_GT_B, A_EQ_B};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {LT,GT,EQ} from a plain whole-word integer compare.
  function automatic logic [2:0] ref_flags(input logic [31:0] a, input logic [31:0] b,
                                           input logic tc);
    longint sa;
    longint sb;
    if (tc) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    if (sa == sb)     return 3'b001;
    else if (sa > sb) return 3'b010;
    else              return 3'b100;
  endfunction

  // Cycles from Start to Done: equal leading bytes + 1, capped at 4.
  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 0;
    for (int c = 3; c >= 0; c--) begin
      if (a[c*8 +: 8] == b[c*8 +: 8]) k++;
      else break;
    end
    return (k == 4) ? 4 : k + 1;
  endfunction

  // Called at a falling edge; returns at the falling edge of the DONE cycle.
  // poke drives a conflicting Start during the first RUN cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic tc,
                       input bit poke, input string tag);
    logic [2:0] ef;
    int         el;
    int         n;
    ef = ref_flags(a, b, tc);
    el = ref_lat(a, b);
    Start          = 1'b1;
    DataA          = a;
    DataB          = b;
    TwosComplement = tc;
    @(negedge Clock);
    Start = 1'b0;
    chk({tag, " first_run"}, 32'(outs()), 32'(5'b10000));
    if (poke) begin
      Start          = 1'b1;
      DataA          = ~a;
      DataB          = b ^ 32'h5A5A_5A5A;
      TwosComplement = ~tc;
    end
    n = 0;
    while (n < 12) begin
      @(negedge Clock);
      Start = 1'b0;
      n++;
      if (Done) break;
      chk({tag, " busy"}, 32'({Busy, Done}), 32'(2'b10));
    end
    chk({tag, " latency"}, 32'(n), 32'(el));
    chk({tag, " result"}, 32'(outs()), 32'({2'b01, ef}));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] mask;
    int          k;

    Reset          = 1'b1;
    Start          = 1'b0;
    TwosComplement = 1'b0;
    DataA          = '0;
    DataB          = '0;
    repeat (3) @(negedge Clock);
    chk("reset_outs", 32'(outs()), 32'(5'b00000));
    Reset = 1'b0;
    @(negedge Clock);
    chk("idle_outs", 32'(outs()), 32'(5'b00000));

    // Signed, differ only in last byte.
    do_op(32'h1234_5678, 32'h1234_5679, 1'b1, 1'b0, "lastbyte");
    @(negedge Clock);
    chk("after_done", 32'(outs()), 32'(5'b00100));

    // Same operands, signed then unsigned.
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, "msb_signed");
    @(negedge Clock);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, "msb_unsigned");
    @(negedge Clock);

    // Equal operands, flags hold while idle.
    do_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, "equal");
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      chk($sformatf("eq_hold%0d", i), 32'(outs()), 32'(5'b00001));
    end

    // Start during RUN is ignored.
    do_op(32'h00FF_0000, 32'h00FE_0000, 1'b0, 1'b1, "ignore_start");
    @(negedge Clock);

    // Reset in the second RUN cycle aborts with no Done.
    Start          = 1'b1;
    DataA          = 32'hCAFE_F00D;
    DataB          = 32'hCAFE_F00D;
    TwosComplement = 1'b0;
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    chk("abort_running", 32'(outs()), 32'(5'b10000));
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("abort_reset", 32'(outs()), 32'(5'b00000));
    @(negedge Clock);
    chk("abort_no_done", 32'(outs()), 32'(5'b00000));
    do_op(32'h0102_0304, 32'h0102_0404, 1'b0, 1'b0, "post_abort");

    // Back-to-back: new Start accepted in the DONE cycle.
    do_op(32'h7FFF_FFFF, 32'h7FFF_FFFE, 1'b1, 1'b0, "b2b_first");
    do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "b2b_second");

    // Randomised operations with controlled shared leading bytes.
    for (int i = 0; i < 40; i++) begin
      repeat (int'($urandom_range(0, 2))) @(negedge Clock);
      ra = $urandom;
      rb = $urandom;
      k  = int'($urandom_range(0, 4));
      if (k == 4) begin
        rb = ra;
      end else if (k > 0) begin
        mask = ~(32'hFFFF_FFFF >> (8 * k));
        rb   = (ra & mask) | (rb & ~mask);
      end
      do_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $sformatf("rnd%0d", i));
    end

    @(negedge Clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_iterative_comparator
`default_nettype wire

// File: doc/iterative_comparator.md
Name: iterative_comparator

Overview:
- Multi-cycle, parametrised magnitude comparator for the MCU arithmetic group; successor to the single-cycle combinational comparator.
- Compares two NrOfBits-wide operands ChunkBits at a time, most significant chunk first, and stops early at the first differing chunk.
- Signed/unsigned mode is chosen per operation, not per instance; result is registered and announced by a one-cycle Done pulse.
- Intended for wide operands (64/128-bit) where a full-width single-cycle compare would break timing.

Parameters:
- NrOfBits, 32, operand width; must be an integer multiple of ChunkBits.
- ChunkBits, 8, bits compared per cycle; 1 <= ChunkBits <= NrOfBits.
- NrOfChunks, NrOfBits/ChunkBits, derived localparam; not overridable.

Ports:
- Clock  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  request; accepted only in IDLE or DONE.
- TwosComplement  in  1  mode for this operation: 1 = signed, 0 = unsigned; sampled with Start.
- DataA  in  NrOfBits  operand A; sampled with Start.
- DataB  in  NrOfBits  operand B; sampled with Start.
- Busy  out  1  high while in RUN.
- Done  out  1  one-cycle pulse when the result becomes valid.
- A_EQ_B  out  1  registered result.
- A_GT_B  out  1  registered result.
- A_LT_B  out  1  registered result.

Behaviour:
- Reset: state IDLE; Busy, Done, A_EQ_B, A_GT_B and A_LT_B all 0; operand registers 0. A reset during RUN aborts the operation with no Done.
- States and transitions:
  - IDLE: on Start, go to RUN.
  - RUN: exit to DONE as soon as the compare resolves (see below).
  - DONE: lasts exactly one cycle. Start in DONE goes to RUN (back-to-back operation); otherwise go to IDLE.
- Operand acceptance: on an accepted Start, latch DataA, DataB and TwosComplement, set the chunk index to NrOfChunks-1, and clear the result flags to 000.
- Start while in RUN is ignored; the latched operands are not disturbed.
- Signed mode: invert the MSB (bit NrOfBits-1) of both latched operands, then compare unsigned. This is equivalent to a two's-complement compare.
- Each RUN cycle compares chunk[index] of A and B unsigned:
  - A chunk > B chunk: set A_GT_B=1, go to DONE.
  - A chunk < B chunk: set A_LT_B=1, go to DONE.
  - Chunks equal and index=0: set A_EQ_B=1, go to DONE.
  - Chunks equal and index>0: decrement index, stay in RUN.
- Latency: Start to Done is k+1 cycles, where k is the number of equal leading chunks. Minimum 1 cycle; maximum NrOfChunks cycles. There is no idle gap between Start and the first compare.
- Done and the three flags are asserted in the same cycle the state is DONE. Exactly one flag is high from that cycle on.
- The flags hold until the next accepted Start, which clears them to 000. The 000 pattern means "no result yet".
- Busy=1 exactly while the state is RUN.
- ChunkBits=NrOfBits is legal: the block degenerates to a registered 1-cycle comparator.

Decomposition:
- Shared package (comparator_pkg):
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE;
  - result-flag ordering constants (EQ, GT, LT).
- One sub-module is natural: chunk_compare, a combinational unsigned ChunkBits compare producing gt/lt/eq. It is instanced once and fed by an index-driven mux.
- Operand holding, the FSM and the result registers stay in the top module.

Test Plan:
- Width 32, chunk 8, signed: A=0x12345678, B=0x12345679 -> Done 4 cycles after Start, LT=1, Busy high for 4 cycles.
- A=0x80000000, B=0x00000001, same instance:
  - signed -> Done after 1 cycle, LT=1;
  - repeated unsigned -> Done after 1 cycle, GT=1.
- A=B=0xDEADBEEF, unsigned -> Done after 4 cycles, EQ=1; flags hold for 10 idle cycles afterwards.
- Start A=0x00FF0000, B=0x00FE0000 -> GT after 2 cycles. Drive Start with different operands in cycle 1 -> ignored, result unchanged.
- Reset asserted in the 2nd RUN cycle of an equal-operand compare -> next cycle all outputs 0, no Done. A new Start then completes normally.
- Start held high through DONE with new operands (A=0xFFFFFFFF signed vs B=0) -> second operation starts without an IDLE cycle and gives LT=1 after 1 cycle.
